// File: rtl/io_pkg.sv
// io_pkg
// Shared constants for the IO input stage: the word addresses the processor
// uses to reach the switch registers, and the bit positions inside the status
// word. No ports; imported by the modules that decode IO addresses.
package io_pkg;

  localparam logic [3:0] IO_ADDR_SPEED  = 4'h4;
  localparam logic [3:0] IO_ADDR_DIR    = 4'h8;
  localparam logic [3:0] IO_ADDR_STATUS = 4'hC;

  // Bit positions inside the status word.
  localparam int STAT_SPD = 0;
  localparam int STAT_DIR = 1;

endpackage

// File: rtl/io_input_conditioner_if.sv
// io_input_conditioner_if
// Processor-side IO read bus for the input conditioner.
//   IOAddr     : IO word address driven by the processor
//   IOReadEn   : one-cycle strobe, high when the processor completes a load
//   IOReadData : read data for IOAddr, combinational from registered state
// Handshake: there is no valid/ready pair. IOReadData is valid whenever IOAddr
// is stable; IOReadEn qualifies a completed load and is only used to trigger
// read side effects (clear-on-read of the status word) on the edge that ends
// the strobe cycle. The slave can never stall the master.
interface io_input_conditioner_if;

  logic [3:0]  IOAddr;
  logic        IOReadEn;
  logic [31:0] IOReadData;

  modport master (
    output IOAddr,
    output IOReadEn,
    input  IOReadData
  );

  modport slave (
    input  IOAddr,
    input  IOReadEn,
    output IOReadData
  );

endinterface

// File: rtl/switch_debounce.sv
// switch_debounce
// One switch bit: two-flop synchronizer, debounce counter, accepted level and
// a one-cycle change pulse.
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   raw_i    : raw asynchronous switch level
//   stable_o : debounced level
//   chg_o    : high for one cycle, on the cycle after stable_o toggles
// DEBOUNCE_CYCLES must lie in 2..(2**CNT_W - 1).
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic chg_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = raw_i;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg_d    = 1'b0;
    if (s2_q == stable_q) begin
      // Level matches (or bounced back): restart the window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Held different for DEBOUNCE_CYCLES edges: accept. The counter never
      // passes CNT_LAST, so it cannot wrap.
      stable_d = s2_q;
      cnt_d    = '0;
      chg_d    = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

  assign stable_o = stable_q;
  assign chg_o    = chg_q;

endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Memory-mapped input stage between the board switches and the processor IO
// read port. Debounces the speed/direction switches, keeps sticky change
// flags and decodes the IO read map.
//   CLK      : system clock (single domain)
//   RESET    : asynchronous active-high reset
//   SW_IN    : raw switches, [1:0] speed, [2] direction
//   bus      : IO read bus (slave side): IOAddr, IOReadEn -> IOReadData
//   SW_CLEAN : debounced switch levels
// Read map: 4'h4 speed, 4'h8 direction, 4'hC status {dir_chg, spd_chg}
// (cleared by a strobed read), anything else reads 0.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [2:0]              SW_IN,
  io_input_conditioner_if.slave   bus,
  output logic [2:0]              SW_CLEAN
);

  logic [2:0] stable;
  logic [2:0] chg;

  for (genvar i = 0; i < 3; i++) begin : g_db
    switch_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .raw_i    (SW_IN[i]),
      .stable_o (stable[i]),
      .chg_o    (chg[i])
    );
  end

  logic [1:0] stat_q, stat_d;
  logic       stat_clr;

  assign stat_clr = bus.IOReadEn && (bus.IOAddr == IO_ADDR_STATUS);

  // Clear first, then set, so an event landing on the clearing edge survives.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end
    if (chg[0] || chg[1]) begin
      stat_d[STAT_SPD] = 1'b1;
    end
    if (chg[2]) begin
      stat_d[STAT_DIR] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  always_comb begin
    bus.IOReadData = 32'h0;
    case (bus.IOAddr)
      IO_ADDR_SPEED:  bus.IOReadData = {30'b0, stable[1:0]};
      IO_ADDR_DIR:    bus.IOReadData = {31'b0, stable[2]};
      IO_ADDR_STATUS: bus.IOReadData = {30'b0, stat_q};
      default:        bus.IOReadData = 32'h0;
    endcase
  end

  assign SW_CLEAN = stable;

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] sw_in;
  logic [2:0] sw_clean;

  io_input_conditioner_if bus();

  io_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .SW_IN    (sw_in),
    .bus      (bus),
    .SW_CLEAN (sw_clean)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  // Driver tasks. All stimulus changes right after a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Combinational read without strobe: no edge consumed.
  task automatic peek(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    bus.IOAddr   = addr;
    bus.IOReadEn = 1'b0;
    exp_q.push_back(exp);
    #1;
    compare(tag, bus.IOReadData);
  endtask

  // Strobed load: sample in the load cycle, then let the ending edge pass.
  task automatic rd_strobe(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    bus.IOAddr   = addr;
    bus.IOReadEn = 1'b1;
    exp_q.push_back(exp);
    #1;
    compare(tag, bus.IOReadData);
    @(posedge clk);
    @(negedge clk);
    bus.IOReadEn = 1'b0;
  endtask

  task automatic chk_clean(input string tag, input logic [2:0] exp);
    exp_q.push_back({29'b0, exp});
    #1;
    compare(tag, {29'b0, sw_clean});
  endtask

  initial begin
    // Reset with all switches high
    rst          = 1'b1;
    sw_in        = 3'b111;
    bus.IOAddr   = 4'h0;
    bus.IOReadEn = 1'b0;
    #1;
    peek("rst_speed", 4'h4, 32'h0);
    peek("rst_dir", 4'h8, 32'h0);
    peek("rst_stat", 4'hC, 32'h0);
    peek("rst_unmapped", 4'h0, 32'h0);
    chk_clean("rst_clean", 3'b000);
    @(negedge clk);
    step(2);
    peek("rst_hold_speed", 4'h4, 32'h0);
    rst = 1'b0;

    step(5);
    peek("rel_speed_e5", 4'h4, 32'h0);
    peek("rel_dir_e5", 4'h8, 32'h0);
    step(1);
    peek("rel_speed_e6", 4'h4, 32'h3);
    peek("rel_dir_e6", 4'h8, 32'h1);
    peek("rel_stat_e6", 4'hC, 32'h0);
    chk_clean("rel_clean_e6", 3'b111);
    step(1);
    peek("rel_stat_e7", 4'hC, 32'h3);
    rd_strobe("rel_stat_rd", 4'hC, 32'h3);
    peek("rel_stat_clr", 4'hC, 32'h0);

    // Return all switches low and clear the resulting flags
    sw_in = 3'b000;
    step(8);
    chk_clean("low_clean", 3'b000);
    rd_strobe("low_stat_rd", 4'hC, 32'h3);
    peek("low_stat_clr", 4'hC, 32'h0);

    // Glitch rejection: bit 0 high for 3 cycles
    sw_in[0] = 1'b1;
    step(3);
    sw_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      peek("glitch_speed", 4'h4, 32'h0);
      peek("glitch_stat", 4'hC, 32'h0);
    end

    // Accept and clear: direction
    sw_in[2] = 1'b1;
    step(5);
    peek("dir_e5", 4'h8, 32'h0);
    step(1);
    peek("dir_e6", 4'h8, 32'h1);
    step(1);
    rd_strobe("dir_rd_noside", 4'h8, 32'h1);
    peek("dir_stat_kept", 4'hC, 32'h2);
    rd_strobe("dir_stat_rd", 4'hC, 32'h2);
    peek("dir_stat_clr", 4'hC, 32'h0);

    // Set beats clear: speed bit 0 accepted at edge 6, flag sets at edge 7,
    // which is also the edge ending the clearing read.
    sw_in[0] = 1'b1;
    step(6);
    peek("sbc_speed", 4'h4, 32'h1);
    rd_strobe("sbc_rd_old", 4'hC, 32'h0);
    peek("sbc_after", 4'hC, 32'h1);
    rd_strobe("sbc_rd2", 4'hC, 32'h1);
    peek("sbc_clr", 4'hC, 32'h0);

    // Bounce restart on bit 1: 1,1,1,0,1,1,1,1 then held
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111; // LSB first
      for (int i = 0; i < 8; i++) begin
        sw_in[1] = pat[i];
        step(1);
        peek("bounce_speed", 4'h4, 32'h1);
        peek("bounce_unmapped", 4'h0, 32'h0);
      end
    end
    step(1);
    peek("bounce_e9", 4'h4, 32'h1);
    step(1);
    peek("bounce_e10", 4'h4, 32'h3);
    peek("bounce_unmapped_end", 4'h0, 32'h0);
    step(1);
    peek("bounce_stat", 4'hC, 32'h1);
    rd_strobe("bounce_stat_rd", 4'hC, 32'h1);

    // Reset mid-count: bit 1 low pending, reset 2 cycles into the count
    sw_in[1] = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    chk_clean("mid_rst_clean", 3'b000);
    peek("mid_rst_speed", 4'h4, 32'h0);
    peek("mid_rst_stat", 4'hC, 32'h0);
    @(negedge clk);
    step(1);
    rst = 1'b0;
    step(5);
    chk_clean("mid_e5", 3'b000);
    step(1);
    chk_clean("mid_e6", 3'b101);
    peek("mid_speed", 4'h4, 32'h1);
    peek("mid_dir", 4'h8, 32'h1);
    peek("mid_stat_e6", 4'hC, 32'h0);
    step(1);
    peek("mid_stat_e7", 4'hC, 32'h3);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Memory-mapped input stage between the board switches and the MIPS `IOReadData` port. It synchronizes and debounces the raw speed and direction switches and presents clean values at fixed IO addresses. It also keeps sticky change flags in a status register, so software can detect a switch change without polling continuously. It replaces the combinational read multiplexer in the top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 20000: number of consecutive stable `CLK` cycles required to accept a new switch level (2 ms at 10 MHz). Legal range is 2 to 32767.
- `CNT_W`, 15: width of each debounce counter. Must satisfy 2^CNT_W > `DEBOUNCE_CYCLES`.

Ports:
- `CLK`  in  1: system clock, the 10 MHz clock-divider output. One clock domain only.
- `RESET`  in  1: asynchronous, active-high reset.
- `SW_IN`  in  3: raw, asynchronous switch inputs.
  - [1:0] = speed
  - [2] = direction
- `IOAddr`  in  4: IO word address from the processor.
- `IOReadEn`  in  1: one-cycle strobe, high when the processor completes a load from `IOAddr`.
- `IOReadData`  out  32: read data for `IOAddr`.
- `SW_CLEAN`  out  3: debounced switch levels, for board LEDs and debug.

## Operation
Each bit of `SW_IN` is processed independently:
- **Synchronizer:** two flip-flops, `s1` then `s2`.
- **Debounce:**
  - If `s2` equals `stable`, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `s2` still differs from `stable`, then on that edge `stable` takes the value of `s2` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never reaches `stable`.
- **Change pulse:** `chg` is high for one cycle, on the cycle after `stable` toggles.

Sticky status flags:
- `spd_chg` is set when either speed bit's `chg` fires.
- `dir_chg` is set when the direction bit's `chg` fires.
- Both flags are cleared on the cycle after `IOReadEn` is high with `IOAddr` = 4'hC.
- If a set and a clear occur in the same cycle, the set wins, so no event is lost.

Read map (combinational from registered state):
- 4'h4 -> {30'b0, `stable`[1:0]} (speed)
- 4'h8 -> {31'b0, `stable`[2]} (direction)
- 4'hC -> {30'b0, `dir_chg`, `spd_chg`} (status)
- any other address -> 32'h0

Other rules:
- `IOReadEn` at addresses 4'h4 or 4'h8 has no side effects.
- `SW_CLEAN` equals `stable`[2:0].

## Timing
Reset state (all asynchronous, all zero):
- `s1`, `s2`, `stable`, the counters, `chg`, `spd_chg` and `dir_chg` are all 0.
- `IOReadData` is 0 at every address.
- `SW_CLEAN` is 3'b000.

Latency and behaviour:
- **Acceptance latency:** a raw level change held steadily is visible in `stable` after 2 + `DEBOUNCE_CYCLES` rising edges of `CLK`. The sticky flag sets one edge later.
- **Read path:** `IOReadData` follows `IOAddr` in the same cycle, with no added register stage. The processor samples it within the load cycle.
- **Clear on read:** the status value returned is the value before the clear. The flags clear on the edge that ends the `IOReadEn` cycle.
- **Bounce inside the window:** if `s2` returns to `stable` before the count completes, the counter clears and the window restarts from 0 at the next difference.
- **Counter width:** the counter saturates at `DEBOUNCE_CYCLES-1` and never wraps. It clears on acceptance.
- **Reset mid-count:** asserting `RESET` discards any partial count and all pending flags. After release, any switch that is high is accepted as a change after the full latency, which sets the corresponding flag.
- **Simultaneous events:** several bits may be accepted on the same edge. Their flags set together.

## Structure
- The shared package `io_pkg` holds the address constants:
  - `IO_ADDR_SPEED` = 4'h4
  - `IO_ADDR_DIR` = 4'h8
  - `IO_ADDR_STATUS` = 4'hC
- `io_pkg` also holds the status bit indices:
  - `STAT_SPD` = 0
  - `STAT_DIR` = 1
- Sub-module `switch_debounce`: one bit, containing the synchronizer, counter, `stable` register and `chg` pulse, parameterized by `DEBOUNCE_CYCLES` and `CNT_W`. It is instantiated three times.
- The top of this block holds the sticky flags and the read multiplexer.

## Test plan
All simulations use `DEBOUNCE_CYCLES` = 4 and `CNT_W` = 3.
- **Reset:** assert `RESET` with `SW_IN` = 3'b111. Every address reads 32'h0 and `SW_CLEAN` = 0. After release, address 4'h4 reads 3 and address 4'h8 reads 1 after exactly 6 edges, and status reads 32'h3 one edge later.
- **Glitch rejection:** drive `SW_IN`[0] high for 3 cycles, then low. `stable` never changes and status stays 0.
- **Accept and clear:** drive `SW_IN`[2] to 1 and hold it. 6 edges later address 4'h8 reads 1. The first `IOReadEn` at 4'hC returns 32'h2; the next read returns 32'h0.
- **Set beats clear:** arrange for a speed acceptance to land on the same edge as an `IOReadEn` at 4'hC. That read returns the old value, and the following read returns bit 0 set.
- **Bounce restart:** toggle `SW_IN`[1] with the pattern 1,1,1,0,1,1,1,1. It is accepted only after the final run of 4 stable cycles plus the synchronizer delay. An unmapped address (4'h0) reads 0 throughout.
- **Reset mid-count:** assert `RESET` 2 cycles into a pending acceptance. The counter, `stable` and flags all return to 0, and after release the full latency applies again.
